// File: rtl/dii_package.sv
// Shared debug-interconnect types: the DII flit plus the ring station's route and
// egress-arbiter state encodings and destination-match helper.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LOCAL,
        R_FWD
    } route_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_FWD,
        A_LOCAL
    } arb_state_t;

    localparam int DII_DEST_W = 16;
    localparam int DII_ID_W   = 10;
    localparam int DII_PAD_W  = DII_DEST_W - DII_ID_W;

    // A destination word only matches when the bits above the module id are all zero.
    function automatic logic destMatch(input logic [DII_DEST_W-1:0] dest,
                                       input logic [DII_ID_W-1:0]   modId);
        return dest == {{DII_PAD_W{1'b0}}, modId};
    endfunction

endpackage

// File: rtl/dii_buffer.sv
// BUF_SIZE-deep flit FIFO with wrap-bit pointers; the head flit is presented
// combinationally and is reusable by any ring stage.
module dii_buffer
    import dii_package::*;
#(
    parameter int BUF_SIZE = 4
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  dii_flit i_flit,
    output logic    o_ready,
    output dii_flit o_flit,
    input  logic    i_ready
);

    localparam int AW = $clog2(BUF_SIZE);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [16:0] r_mem [BUF_SIZE];

    logic w_empty;
    logic w_full;
    logic w_write;
    logic w_read;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        w_empty = (r_wrPtr == r_rdPtr);
        w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                  (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
        w_write = i_flit.valid && !w_full;
        w_read  = !w_empty && i_ready;
        o_ready = !w_full;
        o_flit.valid = !w_empty;
        {o_flit.last, o_flit.data} = r_mem[r_rdPtr[AW-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_read) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wrPtr[AW-1:0]] <= {i_flit.last, i_flit.data};
        end
    end

endmodule

// File: rtl/osd_ring_station.sv
// Ring attachment stage: delivers packets for this module on local_out, forwards the rest
// and merges local_in onto ring_out. OSD_RING_STATION_STATS_EN adds packet counters.
module osd_ring_station
    import dii_package::*;
#(
    parameter int BUF_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  id,
    input  dii_flit     ring_in,
    output logic        ring_in_ready,
    output dii_flit     ring_out,
    input  logic        ring_out_ready,
    output dii_flit     local_out,
    input  logic        local_out_ready,
    input  dii_flit     local_in,
    output logic        local_in_ready
`ifdef OSD_RING_STATION_STATS_EN
    ,
    output logic [15:0] stat_local_pkts,
    output logic [15:0] stat_fwd_pkts
`endif
);

    dii_flit      w_head;
    logic         w_headReady;

    route_state_t r_route;
    arb_state_t   r_arb;
    logic         r_prioLocal;

    logic w_isLocal;
    logic w_routeLocal;
    logic w_routeFwd;
    logic w_reqFwd;
    logic w_reqLocal;
    logic w_pickFwd;
    logic w_pickLocal;
    logic w_grantFwd;
    logic w_grantLocal;
    logic w_popLocal;
    logic w_popFwd;
    logic w_ringXfer;

    dii_buffer #(
        .BUF_SIZE (BUF_SIZE)
    ) u_ingress (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flit  (ring_in),
        .o_ready (ring_in_ready),
        .o_flit  (w_head),
        .i_ready (w_headReady)
    );

    // In R_IDLE the head is a first flit and is routed on the spot, so it can leave
    // in the same cycle the decision is made.
    always_comb begin
        w_isLocal    = destMatch(w_head.data, id);
        w_routeLocal = (r_route == R_LOCAL) ||
                       (r_route == R_IDLE && w_head.valid && w_isLocal);
        w_routeFwd   = (r_route == R_FWD) ||
                       (r_route == R_IDLE && w_head.valid && !w_isLocal);
        w_reqFwd     = w_head.valid && w_routeFwd;
        w_reqLocal   = local_in.valid;

        w_pickFwd    = w_reqFwd && (!w_reqLocal || !r_prioLocal);
        w_pickLocal  = w_reqLocal && (!w_reqFwd || r_prioLocal);
        w_grantFwd   = (r_arb == A_FWD) || (r_arb == A_IDLE && w_pickFwd);
        w_grantLocal = (r_arb == A_LOCAL) || (r_arb == A_IDLE && w_pickLocal);

        local_out.valid = w_head.valid && w_routeLocal;
        local_out.last  = w_head.last;
        local_out.data  = w_head.data;

        ring_out = '0;
        if (w_grantFwd) begin
            ring_out.valid = w_reqFwd;
            ring_out.last  = w_head.last;
            ring_out.data  = w_head.data;
        end else if (w_grantLocal) begin
            ring_out = local_in;
        end

        local_in_ready = w_grantLocal && ring_out_ready;
        w_popLocal     = local_out.valid && local_out_ready;
        w_popFwd       = w_reqFwd && w_grantFwd && ring_out_ready;
        w_headReady    = w_popLocal || w_popFwd;
        w_ringXfer     = ring_out.valid && ring_out_ready;
    end

    // The route is latched as soon as a first flit is seen, so a later id change
    // cannot redirect the rest of that packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_route <= R_IDLE;
        end else begin
            case (r_route)
                R_IDLE: begin
                    if (w_head.valid && !(w_headReady && w_head.last)) begin
                        r_route <= w_isLocal ? R_LOCAL : R_FWD;
                    end
                end
                R_LOCAL, R_FWD: begin
                    if (w_headReady && w_head.last) begin
                        r_route <= R_IDLE;
                    end
                end
                default: r_route <= R_IDLE;
            endcase
        end
    end

    // Priority only flips on a contended pick, so an uncontested grant never costs
    // the other source its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arb       <= A_IDLE;
            r_prioLocal <= 1'b0;
        end else begin
            case (r_arb)
                A_IDLE: begin
                    if (w_reqFwd && w_reqLocal) begin
                        r_prioLocal <= w_pickFwd;
                    end
                    if (w_pickFwd || w_pickLocal) begin
                        if (!(w_ringXfer && ring_out.last)) begin
                            r_arb <= w_pickFwd ? A_FWD : A_LOCAL;
                        end
                    end
                end
                A_FWD, A_LOCAL: begin
                    if (w_ringXfer && ring_out.last) begin
                        r_arb <= A_IDLE;
                    end
                end
                default: r_arb <= A_IDLE;
            endcase
        end
    end

`ifdef OSD_RING_STATION_STATS_EN
    logic [15:0] r_statLocal;
    logic [15:0] r_statFwd;

    // Only packets that arrived from the ring are counted; injected ones are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_statLocal <= '0;
            r_statFwd   <= '0;
        end else begin
            if (w_popLocal && w_head.last) begin
                r_statLocal <= r_statLocal + 16'd1;
            end
            if (w_popFwd && w_head.last) begin
                r_statFwd <= r_statFwd + 16'd1;
            end
        end
    end

    assign stat_local_pkts = r_statLocal;
    assign stat_fwd_pkts   = r_statFwd;
`endif

endmodule

// File: tb/tb_osd_ring_station.sv
// Bench for osd_ring_station: a packet-level model of the station checked every cycle,
// plus directed scenarios with literal expectations on latency, ordering and reset.
module tb_osd_ring_station;
    import dii_package::*;

    localparam int BUF = 4;

    typedef struct {
        logic [15:0] data;
        logic        last;
        bit          toLocal;
    } ing_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id;
    dii_flit     ring_in;
    logic        ring_in_ready;
    dii_flit     ring_out;
    logic        ring_out_ready;
    dii_flit     local_out;
    logic        local_out_ready;
    dii_flit     local_in;
    logic        local_in_ready;
`ifdef OSD_RING_STATION_STATS_EN
    logic [15:0] stat_local_pkts;
    logic [15:0] stat_fwd_pkts;
`endif

    osd_ring_station #(
        .BUF_SIZE (BUF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .ring_in         (ring_in),
        .ring_in_ready   (ring_in_ready),
        .ring_out        (ring_out),
        .ring_out_ready  (ring_out_ready),
        .local_out       (local_out),
        .local_out_ready (local_out_ready),
        .local_in        (local_in),
        .local_in_ready  (local_in_ready)
`ifdef OSD_RING_STATION_STATS_EN
        ,
        .stat_local_pkts (stat_local_pkts),
        .stat_fwd_pkts   (stat_fwd_pkts)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int cycle   = 0;

    dii_flit     ringTx[$];
    dii_flit     localTx[$];
    bit          ringAcc  = 1'b0;
    bit          localAcc = 1'b0;
    logic [15:0] stage[$];

    ing_t        ingQ[$];
    bit          mInPkt;
    bit          mInLocal;
    int          mPkt;
    bit          mFavorLocal;
    logic [15:0] mStatLocal;
    logic [15:0] mStatFwd;

    int          ringAccCycles[$];
    int          localOutCycles[$];
    logic [15:0] ringOutLog[$];
    logic [15:0] localOutLog[$];
    int          ringOutValidCount;

    logic        expLocValid;
    logic        transitAvail;
    logic        expInReady;
    logic        expRingValid;
    logic [15:0] expData;
    logic        expLast;
    int          src;
    logic        ringXfer;
    logic        locXfer;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input bit toRing);
        for (int i = 0; i < stage.size(); i++) begin
            dii_flit f;
            f.valid = 1'b1;
            f.last  = (i == stage.size() - 1);
            f.data  = stage[i];
            if (toRing) ringTx.push_back(f);
            else        localTx.push_back(f);
        end
        stage.delete();
    endtask

    task automatic clearLogs();
        ringAccCycles.delete();
        localOutCycles.delete();
        ringOutLog.delete();
        localOutLog.delete();
        ringOutValidCount = 0;
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n = 0;
        while (!(ringTx.size() == 0 && localTx.size() == 0 && ingQ.size() == 0 &&
                 mPkt == 0 && !local_in.valid && !ring_in.valid) && n < maxCycles) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput({name, " drained"}, 32'(n < maxCycles), 32'd1);
    endtask

    task automatic applyReset();
        ringTx.delete();
        localTx.delete();
        ring_in  = '0;
        local_in = '0;
        rst      = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic checkLog(input string name, input logic [15:0] got[$],
                            input logic [15:0] want[$]);
        checkOutput({name, " length"}, 32'(got.size()), 32'(want.size()));
        if (got.size() == want.size()) begin
            for (int i = 0; i < want.size(); i++) begin
                checkOutput($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(want[i]));
            end
        end
    endtask

    always @(posedge clk) cycle++;

    // Source drivers: pop the flit the station accepted, then present the next one.
    always @(posedge clk) begin
        if (ringAcc && ringTx.size() > 0) void'(ringTx.pop_front());
        #1;
        ring_in = (ringTx.size() > 0) ? ringTx[0] : '0;
    end

    always @(posedge clk) begin
        if (localAcc && localTx.size() > 0) void'(localTx.pop_front());
        #1;
        local_in = (localTx.size() > 0) ? localTx[0] : '0;
    end

    // Packet-level model: the ingress queue holds every accepted flit tagged with its
    // destination; egress follows the round-robin / no-interleave rules.
    always @(negedge clk) begin
        if (rst) begin
            ingQ.delete();
            mInPkt      = 1'b0;
            mInLocal    = 1'b0;
            mPkt        = 0;
            mFavorLocal = 1'b0;
            mStatLocal  = '0;
            mStatFwd    = '0;
            ringAcc     = 1'b0;
            localAcc    = 1'b0;
        end else begin
            expLocValid  = (ingQ.size() > 0) && ingQ[0].toLocal;
            transitAvail = (ingQ.size() > 0) && !ingQ[0].toLocal;
            expInReady   = (ingQ.size() < BUF);

            if (mPkt != 0)                           src = mPkt;
            else if (transitAvail && local_in.valid) src = mFavorLocal ? 2 : 1;
            else if (transitAvail)                   src = 1;
            else if (local_in.valid)                 src = 2;
            else                                     src = 0;

            expRingValid = (src == 1 && transitAvail) || (src == 2 && local_in.valid);
            if (src == 1 && transitAvail) begin
                expData = ingQ[0].data;
                expLast = ingQ[0].last;
            end else begin
                expData = local_in.data;
                expLast = local_in.last;
            end

            checkOutput("ring_in_ready", 32'(ring_in_ready), 32'(expInReady));
            checkOutput("local_out.valid", 32'(local_out.valid), 32'(expLocValid));
            if (expLocValid) begin
                checkOutput("local_out.data", 32'(local_out.data), 32'(ingQ[0].data));
                checkOutput("local_out.last", 32'(local_out.last), 32'(ingQ[0].last));
            end
            checkOutput("ring_out.valid", 32'(ring_out.valid), 32'(expRingValid));
            if (expRingValid) begin
                checkOutput("ring_out.data", 32'(ring_out.data), 32'(expData));
                checkOutput("ring_out.last", 32'(ring_out.last), 32'(expLast));
            end
            checkOutput("local_in_ready", 32'(local_in_ready),
                        32'((src == 2) && ring_out_ready));
`ifdef OSD_RING_STATION_STATS_EN
            checkOutput("stat_local_pkts", 32'(stat_local_pkts), 32'(mStatLocal));
            checkOutput("stat_fwd_pkts", 32'(stat_fwd_pkts), 32'(mStatFwd));
`endif

            if (ring_in.valid && ring_in_ready) ringAccCycles.push_back(cycle);
            if (ring_out.valid && ring_out_ready) ringOutLog.push_back(ring_out.data);
            if (ring_out.valid) ringOutValidCount++;
            if (local_out.valid && local_out_ready) begin
                localOutLog.push_back(local_out.data);
                localOutCycles.push_back(cycle);
            end
            ringAcc  = ring_in.valid && ring_in_ready;
            localAcc = local_in.valid && local_in_ready;

            ringXfer = expRingValid && ring_out_ready;
            locXfer  = expLocValid && local_out_ready;
            if (mPkt == 0 && src != 0) begin
                if (transitAvail && local_in.valid) mFavorLocal = (src == 1);
                mPkt = src;
            end
            if (ringXfer && expLast) mPkt = 0;
            if (ringXfer && src == 1) begin
                if (expLast) mStatFwd = mStatFwd + 16'd1;
                void'(ingQ.pop_front());
            end
            if (locXfer) begin
                if (ingQ[0].last) mStatLocal = mStatLocal + 16'd1;
                void'(ingQ.pop_front());
            end
            if (ring_in.valid && expInReady) begin
                ing_t e;
                e.data = ring_in.data;
                e.last = ring_in.last;
                if (!mInPkt) mInLocal = (ring_in.data == {6'h0, id});
                e.toLocal = mInLocal;
                mInPkt = !ring_in.last;
                ingQ.push_back(e);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        id              = 10'h005;
        ring_in         = '0;
        local_in        = '0;
        ring_out_ready  = 1'b1;
        local_out_ready = 1'b1;
        clearLogs();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("reset ring_in_ready", 32'(ring_in_ready), 32'd1);
        checkOutput("reset ring_out.valid", 32'(ring_out.valid), 32'd0);
        checkOutput("reset local_out.valid", 32'(local_out.valid), 32'd0);
        checkOutput("reset local_in_ready", 32'(local_in_ready), 32'd0);

        // Packet addressed to id 0x005 lands on local_out one cycle after ingress.
        clearLogs();
        stage = '{16'h0005, 16'h1234, 16'h8000};
        applyStimulus(1'b1);
        waitIdle(50, "local pkt");
        checkLog("local pkt flits", localOutLog, '{16'h0005, 16'h1234, 16'h8000});
        checkOutput("local pkt ring_out idle", 32'(ringOutValidCount), 32'd0);
        if (localOutCycles.size() > 0 && ringAccCycles.size() > 0) begin
            checkOutput("local pkt latency",
                        32'(localOutCycles[0] - ringAccCycles[0]), 32'd1);
        end

        // Non-matching destinations, including one whose upper bits are set.
        clearLogs();
        stage = '{16'h0007, 16'hBEEF};
        applyStimulus(1'b1);
        waitIdle(50, "fwd 0x0007");
        checkLog("fwd 0x0007", ringOutLog, '{16'h0007, 16'hBEEF});
        checkOutput("fwd 0x0007 local idle", 32'(localOutCycles.size()), 32'd0);

        clearLogs();
        stage = '{16'h0405, 16'hCAFE};
        applyStimulus(1'b1);
        waitIdle(50, "fwd 0x0405");
        checkLog("fwd 0x0405", ringOutLog, '{16'h0405, 16'hCAFE});
        checkOutput("fwd 0x0405 local idle", 32'(localOutCycles.size()), 32'd0);

        // Contention: transit wins first from reset priority, local wins the repeat.
        clearLogs();
        stage = '{16'h0009, 16'hA001, 16'hA002, 16'hA003};
        applyStimulus(1'b1);
        @(posedge clk);
        #2;
        stage = '{16'h00C0, 16'hC001, 16'hC002};
        applyStimulus(1'b0);
        waitIdle(100, "arb round 1");
        checkLog("arb round 1", ringOutLog,
                 '{16'h0009, 16'hA001, 16'hA002, 16'hA003, 16'h00C0, 16'hC001, 16'hC002});

        clearLogs();
        stage = '{16'h0009, 16'hA001, 16'hA002, 16'hA003};
        applyStimulus(1'b1);
        @(posedge clk);
        #2;
        stage = '{16'h00C0, 16'hC001, 16'hC002};
        applyStimulus(1'b0);
        waitIdle(100, "arb round 2");
        checkLog("arb round 2", ringOutLog,
                 '{16'h00C0, 16'hC001, 16'hC002, 16'h0009, 16'hA001, 16'hA002, 16'hA003});

        // Backpressure: exactly BUF flits accepted, then order preserved on release.
        clearLogs();
        ring_out_ready = 1'b0;
        stage = '{16'h0009, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005};
        applyStimulus(1'b1);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("stall accepted", 32'(ringAccCycles.size()), 32'd4);
        checkOutput("stall ring_in_ready", 32'(ring_in_ready), 32'd0);
        checkOutput("stall head held", 32'(ring_out.data), 32'h0009);
        ring_out_ready = 1'b1;
        waitIdle(100, "stall release");
        checkLog("stall release", ringOutLog,
                 '{16'h0009, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005});

        // Reset in the middle of a stalled packet discards it.
        ring_out_ready = 1'b0;
        stage = '{16'h0009, 16'hE001, 16'hE002, 16'hE003, 16'hE004, 16'hE005};
        applyStimulus(1'b1);
        repeat (6) @(posedge clk);
        #2;
        applyReset();
        checkOutput("mid-reset ring_out.valid", 32'(ring_out.valid), 32'd0);
        checkOutput("mid-reset local_out.valid", 32'(local_out.valid), 32'd0);
        checkOutput("mid-reset local_in_ready", 32'(local_in_ready), 32'd0);
        checkOutput("mid-reset ring_in_ready", 32'(ring_in_ready), 32'd1);
        ring_out_ready = 1'b1;
        clearLogs();
        stage = '{16'h0005, 16'hF001};
        applyStimulus(1'b1);
        waitIdle(50, "post-reset pkt");
        checkLog("post-reset local", localOutLog, '{16'h0005, 16'hF001});
        checkOutput("post-reset ring_out idle", 32'(ringOutLog.size()), 32'd0);

`ifdef OSD_RING_STATION_STATS_EN
        applyReset();
        clearLogs();
        for (int i = 0; i < 65536; i++) begin
            ringTx.push_back('{valid: 1'b1, last: 1'b1, data: 16'h0005});
        end
        waitIdle(70000, "stats wrap");
        checkOutput("stats wrap delivered", 32'(localOutCycles.size()), 32'd65536);
        checkOutput("stats wrap local", 32'(stat_local_pkts), 32'd0);
        checkOutput("stats wrap fwd", 32'(stat_fwd_pkts), 32'd0);
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
